// File: rtl/mem_access.sv
// Memory-access pipeline stage: latches the execute-stage bundle, runs one bus transaction per
// load/store and presents the writeback result. Optional alignment check: MEM_ALIGN_CHECK_EN.
module mem_access (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_in,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    input  logic [2:0]  ex_ls_type,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic [4:0]  ex_write_reg,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_inst,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_write_reg,
    output logic        wb_reg_write,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_inst,
    output logic        mem_stall,
    output logic        addr_err,
    output logic [31:0] badvaddr
);

    localparam logic [2:0] LsLb  = 3'd0;
    localparam logic [2:0] LsLbu = 3'd1;
    localparam logic [2:0] LsLh  = 3'd2;
    localparam logic [2:0] LsLhu = 3'd3;
    localparam logic [2:0] LsSb  = 3'd5;
    localparam logic [2:0] LsSh  = 3'd6;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_addr;
        logic [31:0] store_data;
        logic [2:0]  ls_type;
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  write_reg;
        logic [31:0] pc;
        logic [31:0] inst;
    } stage_t;

    function automatic logic [1:0] ls_size(input logic [2:0] lt);
        logic [1:0] sz;
        case (lt)
            LsLb, LsLbu, LsSb: sz = 2'd0;
            LsLh, LsLhu, LsSh: sz = 2'd1;
            default:           sz = 2'd2;
        endcase
        return sz;
    endfunction

    state_e      state_q, state_d;
    stage_t      stage_q, stage_d;
    logic [31:0] load_buf_q, load_buf_d;
    logic        capture;
    logic        in_flight;
    logic        ex_fault;
    logic        fault_q;

    // Capture only from IDLE/DONE: the data_ok cycle drops mem_stall, but the load result still
    // has to be presented in DONE before the stage may advance.
    assign capture = !stall_in && !mem_stall && (state_q == StIdle || state_q == StDone);

`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0] ex_size;
    logic       fault_d;

    always_comb begin
        ex_size  = ls_size(ex_ls_type);
        ex_fault = (ex_mem_read || ex_mem_write) &&
                   ((ex_size == 2'd1 && ex_mem_addr[0]) ||
                    (ex_size == 2'd2 && ex_mem_addr[1:0] != 2'b00));
        fault_d  = capture ? ex_fault : fault_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign addr_err = fault_q;
    assign badvaddr = fault_q ? stage_q.mem_addr : 32'd0;
`else
    assign ex_fault = 1'b0;
    assign fault_q  = 1'b0;
    assign addr_err = 1'b0;
    assign badvaddr = 32'd0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; data_ok is only looked at in WAIT
    always_comb begin
        state_d = state_q;
        if (capture) begin
            if (ex_mem_read || ex_mem_write) begin
                state_d = ex_fault ? StDone : StReq;
            end else begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StReq:   if (data_addr_ok) state_d = StWait;
                StWait:  if (data_data_ok) state_d = StDone;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        data_req  = 1'b0;
        mem_stall = 1'b0;
        in_flight = 1'b0;
        unique case (state_q)
            StReq: begin
                data_req  = 1'b1;
                mem_stall = 1'b1;
                in_flight = 1'b1;
            end
            StWait: begin
                mem_stall = !data_data_ok;
                in_flight = 1'b1;
            end
            default: ;
        endcase
    end

    // Stage register and load buffer
    always_comb begin
        stage_d = stage_q;
        if (capture) begin
            stage_d.alu_result = ex_alu_result;
            stage_d.mem_addr   = ex_mem_addr;
            stage_d.store_data = ex_store_data;
            stage_d.ls_type    = ex_ls_type;
            stage_d.reg_write  = ex_reg_write;
            stage_d.mem_to_reg = ex_mem_to_reg;
            stage_d.write_reg  = ex_write_reg;
            stage_d.pc         = ex_pc;
            stage_d.inst       = ex_inst;
        end
        load_buf_d = (state_q == StWait && data_data_ok) ? data_rdata : load_buf_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q    <= '0;
            load_buf_q <= 32'd0;
        end else begin
            stage_q    <= stage_d;
            load_buf_q <= load_buf_d;
        end
    end

    // Bus request fields come straight from the held stage register, so they stay stable
    // for the whole REQ phase.
    always_comb begin
        data_addr = stage_q.mem_addr;
        data_size = ls_size(stage_q.ls_type);
        data_wr   = (stage_q.ls_type >= LsSb);
        case (stage_q.ls_type)
            LsSb:    data_wdata = {4{stage_q.store_data[7:0]}};
            LsSh:    data_wdata = {2{stage_q.store_data[15:0]}};
            default: data_wdata = stage_q.store_data;
        endcase
    end

    // Little-endian lane extraction and writeback
    logic [31:0] shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    always_comb begin
        shifted   = load_buf_q >> {stage_q.mem_addr[1:0], 3'b000};
        load_byte = shifted[7:0];
        load_half = stage_q.mem_addr[1] ? load_buf_q[31:16] : load_buf_q[15:0];
        case (stage_q.ls_type)
            LsLb:    load_data = {{24{load_byte[7]}}, load_byte};
            LsLbu:   load_data = {24'd0, load_byte};
            LsLh:    load_data = {{16{load_half[15]}}, load_half};
            LsLhu:   load_data = {16'd0, load_half};
            default: load_data = load_buf_q;
        endcase

        wb_result    = stage_q.mem_to_reg ? load_data : stage_q.alu_result;
        wb_write_reg = stage_q.write_reg;
        wb_pc        = stage_q.pc;
        wb_inst      = stage_q.inst;
        // Also masked in the data_ok cycle, before the load buffer holds the new word
        wb_reg_write = stage_q.reg_write && !mem_stall && !in_flight && !fault_q;
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: loads, stores, stall hold, reset abort and the
// misaligned-access behaviour of both builds.
module tb_mem_access;

    logic        clk;
    logic        rstn;
    logic        stall_in;
    logic [31:0] ex_alu_result, ex_mem_addr, ex_store_data, ex_pc, ex_inst;
    logic [2:0]  ex_ls_type;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [4:0]  ex_write_reg;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] wb_result, wb_pc, wb_inst, badvaddr;
    logic [4:0]  wb_write_reg;
    logic        wb_reg_write, mem_stall, addr_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .stall_in     (stall_in),
        .ex_alu_result(ex_alu_result),
        .ex_mem_addr  (ex_mem_addr),
        .ex_store_data(ex_store_data),
        .ex_ls_type   (ex_ls_type),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_reg_write (ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg),
        .ex_write_reg (ex_write_reg),
        .ex_pc        (ex_pc),
        .ex_inst      (ex_inst),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .wb_result    (wb_result),
        .wb_write_reg (wb_write_reg),
        .wb_reg_write (wb_reg_write),
        .wb_pc        (wb_pc),
        .wb_inst      (wb_inst),
        .mem_stall    (mem_stall),
        .addr_err     (addr_err),
        .badvaddr     (badvaddr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic set_ex(input logic [2:0] lt, input logic rd, input logic wr, input logic rw,
                          input logic m2r, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] alu, input logic [4:0] wreg,
                          input logic [31:0] pc);
        ex_ls_type    = lt;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_reg_write  = rw;
        ex_mem_to_reg = m2r;
        ex_mem_addr   = addr;
        ex_store_data = sdata;
        ex_alu_result = alu;
        ex_write_reg  = wreg;
        ex_pc         = pc;
        ex_inst       = ~pc;
    endtask

    task automatic set_nop();
        set_ex(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    endtask

    // Capture edge, then park a NOP on the execute inputs
    task automatic issue();
        @(posedge clk);
        #1;
        set_nop();
    endtask

    // REQ (addr_ok, optionally data_ok too) -> WAIT idle -> WAIT data_ok -> ends in DONE
    task automatic bus_txn(input logic both_ok, input logic [31:0] rdata, output int stalls,
                           output logic [31:0] req_addr, output logic [31:0] req_wdata,
                           output logic [1:0] req_size, output logic req_wr);
        stalls       = 0;
        data_addr_ok = 1'b1;
        data_data_ok = both_ok;
        data_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("req_data_req", 32'(data_req), 32'd1);
        check_eq("req_wb_reg_write", 32'(wb_reg_write), 32'd0);
        req_addr  = data_addr;
        req_wdata = data_wdata;
        req_size  = data_size;
        req_wr    = data_wr;
        if (mem_stall) stalls++;
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        @(negedge clk);
        check_eq("wait_data_req", 32'(data_req), 32'd0);
        if (mem_stall) stalls++;
        @(posedge clk);
        #1;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        @(negedge clk);
        if (mem_stall) stalls++;
        @(posedge clk);
        #1;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        @(negedge clk);
    endtask

    task automatic run_load(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        int          stalls;
        logic [31:0] ra, rw;
        logic [1:0]  rs;
        logic        rwr;
        set_ex(lt, 1'b1, 1'b0, 1'b1, 1'b1, addr, 32'd0, 32'hFFFF_0000, 5'd7, 32'h400);
        issue();
        bus_txn(1'b0, rdata, stalls, ra, rw, rs, rwr);
        check_eq({tag, "_result"}, wb_result, exp);
        check_eq({tag, "_stalls"}, 32'(stalls), 32'd2);
        check_eq({tag, "_wr"}, 32'(rwr), 32'd0);
    endtask

    task automatic run_store(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                             input logic [31:0] rt, input logic both_ok,
                             input logic [31:0] exp_wdata, input logic [1:0] exp_size);
        int          stalls;
        logic [31:0] ra, rw;
        logic [1:0]  rs;
        logic        rwr;
        set_ex(lt, 1'b0, 1'b1, 1'b0, 1'b0, addr, rt, 32'h0, 5'd0, 32'h500);
        issue();
        bus_txn(both_ok, 32'h0, stalls, ra, rw, rs, rwr);
        check_eq({tag, "_wdata"}, rw, exp_wdata);
        check_eq({tag, "_size"}, 32'(rs), 32'(exp_size));
        check_eq({tag, "_wr"}, 32'(rwr), 32'd1);
        check_eq({tag, "_addr"}, ra, addr);
        check_eq({tag, "_stalls"}, 32'(stalls), 32'd2);
        check_eq({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'd0);
    endtask

    initial begin
        int          stalls;
        logic [31:0] ra, rw;
        logic [1:0]  rs;
        logic        rwr;

        rstn         = 1'b0;
        stall_in     = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        set_ex(3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h123, 32'h1, 32'h2, 5'd9, 32'h3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_data_req", 32'(data_req), 32'd0);
        check_eq("rst_mem_stall", 32'(mem_stall), 32'd0);
        check_eq("rst_wb_result", wb_result, 32'd0);
        check_eq("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        check_eq("rst_wb_pc", wb_pc, 32'd0);
        check_eq("rst_addr_err", 32'(addr_err), 32'd0);
        check_eq("rst_badvaddr", badvaddr, 32'd0);
        set_nop();
        rstn = 1'b1;

        // LW 0x100, full handshake
        set_ex(3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 32'h0, 5'd12, 32'h0000_1230);
        issue();
        bus_txn(1'b0, 32'h8899_AABB, stalls, ra, rw, rs, rwr);
        check_eq("lw_result", wb_result, 32'h8899_AABB);
        check_eq("lw_stalls", 32'(stalls), 32'd2);
        check_eq("lw_addr", ra, 32'h100);
        check_eq("lw_size", 32'(rs), 32'd2);
        check_eq("lw_wr", 32'(rwr), 32'd0);
        check_eq("lw_done_stall", 32'(mem_stall), 32'd0);
        check_eq("lw_wb_reg_write", 32'(wb_reg_write), 32'd1);
        check_eq("lw_wb_write_reg", 32'(wb_write_reg), 32'd12);
        check_eq("lw_wb_pc", wb_pc, 32'h0000_1230);
        check_eq("lw_wb_inst", wb_inst, 32'hFFFF_EDCF);

        run_load("lb_103", 3'd0, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
        run_load("lbu_103", 3'd1, 32'h103, 32'h80FF_0000, 32'h0000_0080);
        run_load("lb_102", 3'd0, 32'h102, 32'h80FF_0000, 32'hFFFF_FFFF);
        run_load("lh_102", 3'd2, 32'h102, 32'h80FF_0000, 32'hFFFF_80FF);
        run_load("lhu_102", 3'd3, 32'h102, 32'h80FF_0000, 32'h0000_80FF);
        run_load("lbu_101", 3'd1, 32'h101, 32'h1234_5678, 32'h0000_0056);

        run_store("sh_202", 3'd6, 32'h202, 32'h1234_ABCD, 1'b0, 32'hABCD_ABCD, 2'd1);
        run_store("sb_203", 3'd5, 32'h203, 32'h1234_ABCD, 1'b0, 32'hCDCD_CDCD, 2'd0);
        // addr_ok and data_ok together in REQ: data_ok must be ignored
        run_store("sw_204", 3'd7, 32'h204, 32'h1234_ABCD, 1'b1, 32'h1234_ABCD, 2'd2);

        // ADD with stall_in held for 3 cycles
        set_ex(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h5, 5'd3, 32'h600);
        @(posedge clk);
        #1;
        stall_in = 1'b1;
        set_ex(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h77, 5'd4, 32'h604);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_wb_result", wb_result, 32'h5);
            check_eq("stall_data_req", 32'(data_req), 32'd0);
            check_eq("stall_wb_reg_write", 32'(wb_reg_write), 32'd1);
        end
        check_eq("stall_wb_write_reg", 32'(wb_write_reg), 32'd3);
        stall_in = 1'b0;
        @(negedge clk);
        check_eq("unstall_wb_result", wb_result, 32'h77);
        set_nop();

        // Reset while waiting for data_ok
        set_ex(3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'd0, 32'h0, 5'd8, 32'h700);
        issue();
        data_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        check_eq("abort_in_wait", 32'(mem_stall), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("abort_data_req", 32'(data_req), 32'd0);
        check_eq("abort_mem_stall", 32'(mem_stall), 32'd0);
        check_eq("abort_wb_write_reg", 32'(wb_write_reg), 32'd0);
        check_eq("abort_wb_pc", wb_pc, 32'd0);
        @(negedge clk);
        rstn         = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        check_eq("late_ok_mem_stall", 32'(mem_stall), 32'd0);
        check_eq("late_ok_data_req", 32'(data_req), 32'd0);
        check_eq("late_ok_wb_result", wb_result, 32'd0);
        set_ex(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h9, 5'd2, 32'h800);
        issue();
        @(negedge clk);
        check_eq("post_rst_add", wb_result, 32'h9);

        // Misaligned LW at 0x102
        set_ex(3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'd0, 32'h0, 5'd5, 32'h900);
`ifdef MEM_ALIGN_CHECK_EN
        @(posedge clk);
        #1;
        stall_in = 1'b1;
        set_nop();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("align_data_req", 32'(data_req), 32'd0);
            check_eq("align_addr_err", 32'(addr_err), 32'd1);
            check_eq("align_badvaddr", badvaddr, 32'h102);
            check_eq("align_wb_reg_write", 32'(wb_reg_write), 32'd0);
            check_eq("align_mem_stall", 32'(mem_stall), 32'd0);
        end
        stall_in = 1'b0;
`else
        issue();
        bus_txn(1'b0, 32'h1122_3344, stalls, ra, rw, rs, rwr);
        check_eq("noalign_addr", ra, 32'h102);
        check_eq("noalign_result", wb_result, 32'h1122_3344);
        check_eq("noalign_addr_err", 32'(addr_err), 32'd0);
        check_eq("noalign_badvaddr", badvaddr, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
